// File: rtl/alm_pkg.sv
// alm_pkg: shared definitions for the approximate logarithmic multiplier.
// Contents:
//   - ALM_MAXW / ALM_KW_MAX : largest supported operand width and its index width
//   - alm_kw()     : leading-one index width for a given operand width
//   - alm_frac_w() : fractional mantissa width (bits below the leading one)
//   - alm_lead_one(): index of the most significant set bit
//   - stage1_t / stage2_t : pipeline stage registers, sized for the widest
//     build; narrower builds zero-fill and ignore the upper bits.
package alm_pkg;

  localparam int ALM_MAXW   = 16;
  localparam int ALM_KW_MAX = 4;

  function automatic int alm_kw(input int width);
    return $clog2(width);
  endfunction

  function automatic int alm_frac_w(input int width);
    return width - 1;
  endfunction

  // Highest set bit wins because the loop runs upward; a zero input yields 0.
  function automatic logic [ALM_KW_MAX-1:0] alm_lead_one(input logic [ALM_MAXW-1:0] v);
    logic [ALM_KW_MAX-1:0] idx;
    idx = {ALM_KW_MAX{1'b0}};
    for (int i = 0; i < ALM_MAXW; i++) begin
      if (v[i]) begin
        idx = ALM_KW_MAX'(i);
      end
    end
    return idx;
  endfunction

  typedef struct packed {
    logic                valid;
    logic                sign;
    logic                zero;
    logic [ALM_MAXW-1:0] abs_a;
    logic [ALM_MAXW-1:0] abs_b;
  } stage1_t;

  typedef struct packed {
    logic                  valid;
    logic                  sign;
    logic                  zero;
    logic [ALM_KW_MAX-1:0] k1;
    logic [ALM_KW_MAX-1:0] k2;
    logic [ALM_MAXW-2:0]   x1_t;
    logic [ALM_MAXW-2:0]   x2_t;
  } stage2_t;

endpackage

// File: rtl/alm_lod.sv
// alm_lod: leading-one detector, left-aligner and mantissa truncator for one
// unsigned operand magnitude.
// Parameters: WIDTH (operand width), TRUNC (fraction bits kept).
// Ports:
//   i_val  in  WIDTH        unsigned magnitude
//   o_k    out clog2(WIDTH) index of the leading one (0 for a zero input)
//   o_x_t  out TRUNC        top TRUNC bits of the fraction below the leading one
// Build option ALM_TRUNC_BIAS_EN: when defined, the LSB of o_x_t is forced to 1
// if any discarded fraction bit is set (sticky bias toward the true mean).
module alm_lod
  import alm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic [WIDTH-1:0]            i_val,
  output logic [alm_kw(WIDTH)-1:0]    o_k,
  output logic [TRUNC-1:0]            o_x_t
);

  localparam int KW   = alm_kw(WIDTH);
  localparam int FW   = alm_frac_w(WIDTH);
  localparam int DROP = FW - TRUNC;

  logic [ALM_KW_MAX-1:0] w_idx;
  logic [WIDTH-1:0]      w_aligned;
  logic [FW-1:0]         w_x;
  logic [TRUNC-1:0]      w_x_floor;
  logic                  w_unused;

  // Find the leading one and shift it up to the MSB so the fraction is left-aligned.
  always_comb begin
    w_idx     = alm_lead_one(ALM_MAXW'(i_val));
    w_aligned = i_val << (ALM_KW_MAX'(WIDTH - 1) - w_idx);
    w_x       = w_aligned[FW-1:0];
    w_x_floor = w_x[FW-1 -: TRUNC];
  end

  assign o_k = w_idx[KW-1:0];

  generate
    if (DROP > 0) begin : g_drop
`ifdef ALM_TRUNC_BIAS_EN
      logic w_sticky;
      assign w_sticky = |w_x[DROP-1:0];
      assign o_x_t    = w_x_floor | TRUNC'(w_sticky);
`else
      assign o_x_t = w_x_floor;
`endif
    end else begin : g_nodrop
      // Every fraction bit is kept, so there is nothing to bias.
      assign o_x_t = w_x_floor;
    end
  endgenerate

  // The implicit leading one and the dropped bits are intentionally not needed.
  assign w_unused = ^{w_aligned[WIDTH-1], w_idx, w_x};

endmodule

// File: rtl/approx_log_mult_pipe.sv
// approx_log_mult_pipe: three-stage pipelined signed Mitchell approximate
// multiplier with truncated mantissas and valid/ready flow control.
// Parameters: WIDTH (4..16), TRUNC (1..WIDTH-1).
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  pair is accepted this cycle (combinational from out_valid/out_ready)
//   a, b       in   WIDTH-bit signed operands
//   out_valid  out  result valid (registered)
//   out_ready  in   downstream accepts result
//   result     out  2*WIDTH-bit signed approximate product (registered)
// Build option ALM_TRUNC_BIAS_EN: enables sticky truncation bias in alm_lod.
// Pipeline: stage 1 sign/abs/zero, stage 2 leading-one + truncation,
// stage 3 mantissa add, antilog shift, sign restore into the output register.
// A single advance signal moves every stage together; bubbles are kept.
module approx_log_mult_pipe
  import alm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int KW = alm_kw(WIDTH);
  localparam int PW = TRUNC + 2 * WIDTH + 1;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [KW:0]        ONE_K  = {{KW{1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  stage1_t r_s1;
  stage2_t r_s2;
  logic    r_out_valid;
  logic [2*WIDTH-1:0] r_result;

  logic w_adv;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [KW-1:0]      w_k1;
  logic [KW-1:0]      w_k2;
  logic [TRUNC-1:0]   w_x1_t;
  logic [TRUNC-1:0]   w_x2_t;
  logic [TRUNC:0]     w_f;
  logic [KW:0]        w_ks;
  logic [TRUNC:0]     w_mant;
  logic [KW:0]        w_sh;
  logic [PW-1:0]      w_prod;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_res;
  logic               w_unused;

  assign w_adv     = !r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // Stage 1 combinational: magnitudes; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    w_abs_a = a[WIDTH-1] ? (~a + ONE_W) : a;
    w_abs_b = b[WIDTH-1] ? (~b + ONE_W) : b;
  end

  alm_lod #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_lod_a (
    .i_val (r_s1.abs_a[WIDTH-1:0]),
    .o_k   (w_k1),
    .o_x_t (w_x1_t)
  );

  alm_lod #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_lod_b (
    .i_val (r_s1.abs_b[WIDTH-1:0]),
    .o_k   (w_k2),
    .o_x_t (w_x2_t)
  );

  // Stage 3 combinational: add log mantissas, then antilog by shifting 1.f.
  always_comb begin
    w_f  = {1'b0, r_s2.x1_t[TRUNC-1:0]} + {1'b0, r_s2.x2_t[TRUNC-1:0]};
    w_ks = {1'b0, r_s2.k1[KW-1:0]} + {1'b0, r_s2.k2[KW-1:0]};
    if (w_f[TRUNC]) begin
      // Mantissa sum crossed 1.0: f already carries the implicit one, exponent +1.
      w_mant = w_f;
      w_sh   = w_ks + ONE_K;
    end else begin
      w_mant = {1'b1, w_f[TRUNC-1:0]};
      w_sh   = w_ks;
    end
    w_prod = PW'(w_mant) << w_sh;
    w_mag  = w_prod[TRUNC +: 2*WIDTH];
    if (r_s2.zero) begin
      w_res = {(2*WIDTH){1'b0}};
    end else if (r_s2.sign) begin
      w_res = ~w_mag + ONE_2W;
    end else begin
      w_res = w_mag;
    end
  end

  // Pipeline registers: every stage moves only on the shared advance signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= {(2*WIDTH){1'b0}};
    end else if (w_adv) begin
      r_s1.valid  <= in_valid;
      r_s1.sign   <= a[WIDTH-1] ^ b[WIDTH-1];
      r_s1.zero   <= (a == {WIDTH{1'b0}}) | (b == {WIDTH{1'b0}});
      r_s1.abs_a  <= ALM_MAXW'(w_abs_a);
      r_s1.abs_b  <= ALM_MAXW'(w_abs_b);

      r_s2.valid  <= r_s1.valid;
      r_s2.sign   <= r_s1.sign;
      r_s2.zero   <= r_s1.zero;
      r_s2.k1     <= ALM_KW_MAX'(w_k1);
      r_s2.k2     <= ALM_KW_MAX'(w_k2);
      r_s2.x1_t   <= (ALM_MAXW-1)'(w_x1_t);
      r_s2.x2_t   <= (ALM_MAXW-1)'(w_x2_t);

      r_out_valid <= r_s2.valid;
      r_result    <= r_s2.valid ? w_res : {(2*WIDTH){1'b0}};
    end else begin
      r_out_valid <= r_out_valid;
      r_result    <= r_result;
    end
  end

  // Upper struct bits (unused below 16-bit builds) and the shifted-out product bits.
  assign w_unused = ^{r_s1.abs_a, r_s1.abs_b, r_s2.k1, r_s2.k2, r_s2.x1_t, r_s2.x2_t, w_prod};

endmodule

// File: tb/tb_approx_log_mult_pipe.sv
module tb_approx_log_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a8 = 8'd0;
  logic [7:0]  b8 = 8'd0;
  logic [11:0] a12 = 12'd0;
  logic [11:0] b12 = 12'd0;
  logic        rdy8, rdy12, ov8, ov12;
  logic [15:0] r8;
  logic [23:0] r12;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int retired = 0;

  // Reference pipeline occupancy: slot 2 is what the output must show.
  bit     mv8[3];
  longint mr8[3];
  bit     mv12[3];
  longint mr12[3];

`ifdef ALM_TRUNC_BIAS_EN
  localparam longint EXP_37X1 = 38;
`else
  localparam longint EXP_37X1 = 36;
`endif

  always #5 clk = ~clk;

  approx_log_mult_pipe #(.WIDTH(8), .TRUNC(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(out_ready), .result(r8)
  );

  approx_log_mult_pipe #(.WIDTH(12), .TRUNC(6)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy12),
    .a(a12), .b(b12), .out_valid(ov12), .out_ready(out_ready), .result(r12)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leading-one index and truncated fraction of a positive magnitude.
  function automatic void ref_frac(input longint m, input int w, input int t,
                                   output int k, output longint xt);
    longint x;
    int drop;
    k = 0;
    for (int i = 0; i < w; i++) if (m >= (64'sd1 <<< i)) k = i;
    x    = (m - (64'sd1 <<< k)) <<< (w - 1 - k);
    drop = w - 1 - t;
    xt   = x >>> drop;
`ifdef ALM_TRUNC_BIAS_EN
    if ((x & ((64'sd1 <<< drop) - 1)) != 0) xt = xt | 64'sd1;
`endif
  endfunction

  function automatic longint ref_mul(input longint a, input longint b, input int w, input int t);
    longint ma, mb, xa, xb, f, mag;
    int ka, kb, ks;
    if (a == 0 || b == 0) return 0;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    ref_frac(ma, w, t, ka, xa);
    ref_frac(mb, w, t, kb, xb);
    f  = xa + xb;
    ks = ka + kb;
    if (f < (64'sd1 <<< t)) mag = (((64'sd1 <<< t) + f) <<< ks) >>> t;
    else                    mag = (f <<< (ks + 1)) >>> t;
    return ((a < 0) != (b < 0)) ? -mag : mag;
  endfunction

  // One clock cycle: drive at the negedge, check ready, clock, check outputs.
  task automatic step(input bit v, input longint av, input longint bv,
                      input longint a2, input longint b2, input bit ordy);
    bit adv;
    logic signed [7:0]  sa, sb;
    logic signed [11:0] sa2, sb2;
    longint obs12;
    sa = av[7:0];   sb = bv[7:0];
    sa2 = a2[11:0]; sb2 = b2[11:0];
    in_valid = v; a8 = sa; b8 = sb; a12 = sa2; b12 = sb2; out_ready = ordy;
    adv = !mv8[2] || ordy;
    #1;
    chk("in_ready8", rdy8, adv);
    chk("in_ready12", rdy12, adv);
    if (ov8 && ordy) retired++;
    if (v && adv) accepted++;
    @(posedge clk);
    if (adv) begin
      mv8[2] = mv8[1];  mr8[2] = mr8[1];  mv8[1] = mv8[0];  mr8[1] = mr8[0];
      mv12[2] = mv12[1]; mr12[2] = mr12[1]; mv12[1] = mv12[0]; mr12[1] = mr12[0];
      mv8[0] = v;  mr8[0] = ref_mul(sa, sb, 8, 4);
      mv12[0] = v; mr12[0] = ref_mul(sa2, sb2, 12, 6);
    end
    #1;
    chk("out_valid8", ov8, mv8[2]);
    chk("out_valid12", ov12, mv12[2]);
    if (mv8[2]) chk("result8", $signed(r8), mr8[2]);
    if (mv12[2]) begin
      obs12 = $signed(r12);
      chk("result12", obs12, mr12[2]);
      chk("mag_bound12", (obs12 <= 64'sd4194304 && obs12 >= -64'sd4194304), 1);
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mv8[i] = 1'b0; mr8[i] = 0; mv12[i] = 1'b0; mr12[i] = 0;
    end
    accepted = 0;
    retired = 0;
  endtask

  longint da[7]  = '{3, 7, -3, 0, -128, -128, 37};
  longint db[7]  = '{5, 7, 5, -77, -128, 127, 1};
  longint dex[7] = '{14, 48, -14, 0, 16384, -15872, EXP_37X1};

  initial begin
    clear_model();

    // Reset state while rst_n is held low.
    #12;
    chk("rst_out_valid8", ov8, 0);
    chk("rst_result8", r8, 0);
    chk("rst_in_ready8", rdy8, 1);
    chk("rst_out_valid12", ov12, 0);
    chk("rst_result12", r12, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single pairs: result appears on the third edge counting the accepting one.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, da[i], db[i], 0, 0, 1'b1);
      chk("latency_not_early", ov8, 0);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("latency_not_early2", ov8, 0);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      chk("directed_valid", ov8, 1);
      chk("directed_result", $signed(r8), dex[i]);
    end

    // Back-to-back random stream with a 4-cycle downstream stall in the middle.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, longint'($urandom), longint'($urandom), longint'($urandom),
           longint'($urandom), !(i >= 5 && i < 9));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    chk("stream_no_loss", retired, accepted);

    // Reset with three pairs in flight: output clears at once, nothing leaks out.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, longint'($urandom), longint'($urandom), longint'($urandom),
           longint'($urandom), 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid8", ov8, 0);
    chk("midrst_result8", r8, 0);
    chk("midrst_out_valid12", ov12, 0);
    chk("midrst_result12", r12, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 9, -6, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    chk("post_rst_valid", ov8, 1);
    chk("post_rst_result", $signed(r8), -52);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    chk("post_rst_alone", ov8, 0);
    clear_model();

    // Random sweep with random bubbles and backpressure; WIDTH=12 checked bit-exact.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), longint'($urandom), longint'($urandom),
           longint'($urandom), longint'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    chk("sweep_no_loss", retired, accepted);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
